// File: rtl/rv32_decode_stage.sv
// RV32I decode stage: decodes each fetched instruction into func/regs/flags/immediate, queued in a DEPTH-entry buffer.
// Latency 1: an instruction accepted at an edge is visible on out_* in the following cycle.
// Backpressure: in_ready drops only when the buffer is full (registered, independent of out_ready); head holds while stalled.
// Build option: define RV32M_EN to decode the RV32M multiply/divide group; otherwise those encodings are illegal.
module rv32_decode_stage #(
    parameter int XLEN   = 32,
    parameter int FUNC_W = 6,
    parameter int DEPTH  = 2,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_inst,
    input  logic [XLEN-1:0]   in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [XLEN-1:0]   out_pc,
    output logic [FUNC_W-1:0] out_func,
    output logic [4:0]        out_rs1,
    output logic [4:0]        out_rs2,
    output logic [4:0]        out_rd,
    output logic              out_rs1v,
    output logic              out_rs2v,
    output logic              out_rdv,
    output logic [XLEN-1:0]   out_imm,
    output logic              out_illegal,
    output logic [CNT_W-1:0]  illegal_cnt
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CW    = PTR_W + 1;

    // Operation codes (rv32i_defs numbering).
    localparam logic [FUNC_W-1:0] F_NOP = FUNC_W'(0),  F_LUI = FUNC_W'(1),  F_AUIPC = FUNC_W'(2);
    localparam logic [FUNC_W-1:0] F_JAL = FUNC_W'(3),  F_JALR = FUNC_W'(4), F_BEQ = FUNC_W'(5);
    localparam logic [FUNC_W-1:0] F_BNE = FUNC_W'(6),  F_BLT = FUNC_W'(7),  F_BGE = FUNC_W'(8);
    localparam logic [FUNC_W-1:0] F_BLTU = FUNC_W'(9), F_BGEU = FUNC_W'(10), F_LB = FUNC_W'(11);
    localparam logic [FUNC_W-1:0] F_LH = FUNC_W'(12),  F_LW = FUNC_W'(13),  F_LBU = FUNC_W'(14);
    localparam logic [FUNC_W-1:0] F_LHU = FUNC_W'(15), F_SB = FUNC_W'(16),  F_SH = FUNC_W'(17);
    localparam logic [FUNC_W-1:0] F_SW = FUNC_W'(18),  F_ADDI = FUNC_W'(19), F_SLTI = FUNC_W'(20);
    localparam logic [FUNC_W-1:0] F_SLTIU = FUNC_W'(21), F_XORI = FUNC_W'(22), F_ORI = FUNC_W'(23);
    localparam logic [FUNC_W-1:0] F_ANDI = FUNC_W'(24), F_SLLI = FUNC_W'(25), F_SRLI = FUNC_W'(26);
    localparam logic [FUNC_W-1:0] F_SRAI = FUNC_W'(27), F_ADDR = FUNC_W'(28), F_SUBR = FUNC_W'(29);
    localparam logic [FUNC_W-1:0] F_SLLR = FUNC_W'(30), F_SLTR = FUNC_W'(31), F_SLTUR = FUNC_W'(32);
    localparam logic [FUNC_W-1:0] F_XORR = FUNC_W'(33), F_SRLR = FUNC_W'(34), F_SRAR = FUNC_W'(35);
    localparam logic [FUNC_W-1:0] F_ORR = FUNC_W'(36), F_ANDR = FUNC_W'(37), F_BAD = FUNC_W'(63);
`ifdef RV32M_EN
    localparam logic [FUNC_W-1:0] F_MUL = FUNC_W'(38);   // MUL..REMU are F_MUL + funct3
`endif

    typedef enum logic [2:0] {FMT_BAD, FMT_NOP, FMT_U, FMT_J, FMT_I, FMT_SH, FMT_B, FMT_S} fmt_base_t;
    localparam logic [3:0] FMT_R = 4'd8;

    typedef struct packed {
        logic [XLEN-1:0]   pc;
        logic [FUNC_W-1:0] func;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              rs1v;
        logic              rs2v;
        logic              rdv;
        logic [XLEN-1:0]   imm;
        logic              illegal;
    } entry_t;

    logic [FUNC_W-1:0] func;
    logic [3:0]        fmt;
    logic [6:0]        opc;
    logic [2:0]        f3;
    logic [6:0]        f7;
    entry_t            dec;
    entry_t            mem [DEPTH];
    entry_t            head;
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;

    assign opc = in_inst[6:0];
    assign f3  = in_inst[14:12];
    assign f7  = in_inst[31:25];

    // Exact opcode/funct3/funct7 match to an operation code and operand format.
    always_comb begin
        func = F_BAD;
        fmt  = 4'(FMT_BAD);
        case (opc)
            7'b0110111: begin func = F_LUI;   fmt = 4'(FMT_U); end
            7'b0010111: begin func = F_AUIPC; fmt = 4'(FMT_U); end
            7'b1101111: begin func = F_JAL;   fmt = 4'(FMT_J); end
            7'b1100111: begin fmt = 4'(FMT_I); if (f3 == 3'b000) func = F_JALR; end
            7'b1100011: begin
                fmt = 4'(FMT_B);
                case (f3)
                    3'b000: func = F_BEQ;  3'b001: func = F_BNE;
                    3'b100: func = F_BLT;  3'b101: func = F_BGE;
                    3'b110: func = F_BLTU; 3'b111: func = F_BGEU;
                    default: func = F_BAD;
                endcase
            end
            7'b0000011: begin
                fmt = 4'(FMT_I);
                case (f3)
                    3'b000: func = F_LB;  3'b001: func = F_LH; 3'b010: func = F_LW;
                    3'b100: func = F_LBU; 3'b101: func = F_LHU;
                    default: func = F_BAD;
                endcase
            end
            7'b0100011: begin
                fmt = 4'(FMT_S);
                case (f3)
                    3'b000: func = F_SB; 3'b001: func = F_SH; 3'b010: func = F_SW;
                    default: func = F_BAD;
                endcase
            end
            7'b0010011: begin
                fmt = 4'(FMT_I);
                case (f3)
                    3'b000: func = F_ADDI; 3'b010: func = F_SLTI; 3'b011: func = F_SLTIU;
                    3'b100: func = F_XORI; 3'b110: func = F_ORI;  3'b111: func = F_ANDI;
                    3'b001: begin fmt = 4'(FMT_SH); if (f7 == 7'b0000000) func = F_SLLI; end
                    default: begin
                        fmt = 4'(FMT_SH);
                        if (f7 == 7'b0000000)      func = F_SRLI;
                        else if (f7 == 7'b0100000) func = F_SRAI;
                    end
                endcase
            end
            7'b0110011: begin
                fmt = FMT_R;
                if (f7 == 7'b0000000) begin
                    case (f3)
                        3'b000: func = F_ADDR; 3'b001: func = F_SLLR; 3'b010: func = F_SLTR;
                        3'b011: func = F_SLTUR; 3'b100: func = F_XORR; 3'b101: func = F_SRLR;
                        3'b110: func = F_ORR;  default: func = F_ANDR;
                    endcase
                end else if (f7 == 7'b0100000) begin
                    if (f3 == 3'b000)      func = F_SUBR;
                    else if (f3 == 3'b101) func = F_SRAR;
                end
`ifdef RV32M_EN
                else if (f7 == 7'b0000001) func = F_MUL + FUNC_W'(f3);
`endif
            end
            default: func = F_BAD;
        endcase
        if (func == F_BAD) fmt = 4'(FMT_BAD);
        if (in_inst == 32'h0000_0013) begin
            func = F_NOP;
            fmt  = 4'(FMT_NOP);
        end
    end

    // Build the buffer entry: immediates and register-use flags follow the operand format.
    always_comb begin
        dec         = '0;
        dec.pc      = in_pc;
        dec.func    = func;
        dec.rs1     = in_inst[19:15];
        dec.rs2     = in_inst[24:20];
        dec.rd      = in_inst[11:7];
        dec.illegal = (fmt == 4'(FMT_BAD));
        case (fmt)
            4'(FMT_U): begin
                dec.imm = XLEN'($signed({in_inst[31:12], 12'h000}));
                dec.rdv = 1'b1;
            end
            4'(FMT_J): begin
                dec.imm = XLEN'($signed({in_inst[31], in_inst[19:12], in_inst[20], in_inst[30:21], 1'b0}));
                dec.rdv = 1'b1;
            end
            4'(FMT_I): begin
                dec.imm  = XLEN'($signed(in_inst[31:20]));
                dec.rs1v = 1'b1;
                dec.rdv  = 1'b1;
            end
            4'(FMT_SH): begin
                dec.imm  = XLEN'(in_inst[24:20]);
                dec.rs1v = 1'b1;
                dec.rdv  = 1'b1;
            end
            4'(FMT_B): begin
                dec.imm  = XLEN'($signed({in_inst[31], in_inst[7], in_inst[30:25], in_inst[11:8], 1'b0}));
                dec.rs1v = 1'b1;
                dec.rs2v = 1'b1;
            end
            4'(FMT_S): begin
                dec.imm  = XLEN'($signed({in_inst[31:25], in_inst[11:7]}));
                dec.rs1v = 1'b1;
                dec.rs2v = 1'b1;
            end
            FMT_R: begin
                dec.rs1v = 1'b1;
                dec.rs2v = 1'b1;
                dec.rdv  = 1'b1;
            end
            default: ;
        endcase
        if (in_inst[11:7] == 5'd0) dec.rdv = 1'b0;
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready && !flush;
    assign pop       = out_valid && out_ready && !flush;

    // Pointers, occupancy and illegal counter; flush empties the buffer but keeps the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            illegal_cnt <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            if (push && !pop)      count <= count + CW'(1);
            else if (!push && pop) count <= count - CW'(1);
            if (push && dec.illegal && (illegal_cnt != '1)) illegal_cnt <= illegal_cnt + CNT_W'(1);
        end
    end

    // Entry storage; contents only matter while counted as occupied, so no reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= dec;
    end

    assign head        = out_valid ? mem[rd_ptr] : '0;
    assign out_pc      = head.pc;
    assign out_func    = head.func;
    assign out_rs1     = head.rs1;
    assign out_rs2     = head.rs2;
    assign out_rd      = head.rd;
    assign out_rs1v    = head.rs1v;
    assign out_rs2v    = head.rs2v;
    assign out_rdv     = head.rdv;
    assign out_imm     = head.imm;
    assign out_illegal = head.illegal;
endmodule
